// File: rtl/keymgr_op_arbiter.sv
// Arbitrates the key manager operation port between a software and a hardware
// requester. Each granted op is checked against the key manager control state
// before it reaches the core. Output-enable strobes follow only successful
// generate ops, and a stalled core is caught by a cycle timeout.
//
// state  | meaning
// IDLE   | waiting for a request; arbitration and permission check happen here
// ISSUE  | op_start high toward the core, timeout counter running
// RESP   | one-cycle ack to the granted requester, plus strobes on success
// REJECT | one-cycle ack with err for an op that was not permitted
module keymgr_op_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_req,
  input  logic [2:0] sw_op,
  output logic       sw_ack,
  output logic       sw_err,
  input  logic       hw_req,
  input  logic [2:0] hw_op,
  output logic       hw_ack,
  output logic       hw_err,
  input  logic [9:0] ctrl_state,
  output logic       op_start,
  output logic [2:0] op,
  input  logic       op_done,
  output logic       data_hw_en,
  output logic       data_sw_en,
  output logic       data_valid,
  output logic       busy,
  output logic       fault
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [9:0] StCtrlReset    = 10'b1101100001;
  localparam logic [9:0] StCtrlInit     = 10'b0100000100;
  localparam logic [9:0] StCtrlOwnerKey = 10'b1101111110;

  localparam logic [2:0] OpAdvance  = 3'd0;
  localparam logic [2:0] OpGenId    = 3'd1;
  localparam logic [2:0] OpGenSwOut = 3'd2;
  localparam logic [2:0] OpGenHwOut = 3'd3;
  localparam logic [2:0] OpDisable  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RESP   = 2'd2,
    ST_REJECT = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          prio_hw_q, prio_hw_d;  // 1: hw wins a tie
  logic          gnt_hw_q, gnt_hw_d;    // requester owning the op in flight
  logic [2:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          fault_q, fault_d;

  logic          pick_hw;
  logic [2:0]    gnt_op;
  logic          permit;

  // Decides whether an op may run in the given control state. An unknown
  // state encoding or a latched fault blocks everything, including disable.
  function automatic logic op_permitted(input logic [2:0] op_i,
                                        input logic [9:0] st_i,
                                        input logic       fault_i);
    logic known;
    logic ok;
    known = (st_i == StCtrlReset) || (st_i == StCtrlInit) ||
            (st_i == StCtrlOwnerKey);
    case (op_i)
      OpAdvance:                      ok = (st_i == StCtrlReset) || (st_i == StCtrlInit);
      OpGenId, OpGenSwOut, OpGenHwOut: ok = (st_i == StCtrlOwnerKey);
      OpDisable:                      ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok && known && !fault_i;
  endfunction

  // Round-robin pick between the two requesters and the permission verdict
  // for the op that would be granted this cycle.
  always_comb begin
    pick_hw = hw_req && (!sw_req || prio_hw_q);
    gnt_op  = pick_hw ? hw_op : sw_op;
    permit  = op_permitted(gnt_op, ctrl_state, fault_q);
  end

  // Next-state logic; the op and its requester are captured at the grant edge
  // so later changes on the inputs cannot alter the op in flight.
  always_comb begin
    state_d   = state_q;
    prio_hw_d = prio_hw_q;
    gnt_hw_d  = gnt_hw_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    fault_d   = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (sw_req || hw_req) begin
          gnt_hw_d  = pick_hw;
          prio_hw_d = !pick_hw;
          op_d      = gnt_op;
          cnt_d     = '0;
          if (permit) begin
            state_d = ST_ISSUE;
            err_d   = 1'b0;
          end else begin
            state_d = ST_REJECT;
            err_d   = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        // A completion arriving on the expiry cycle still counts as success.
        if (op_done) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          fault_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP, ST_REJECT: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prio_hw_q <= 1'b0;
      gnt_hw_q  <= 1'b0;
      op_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_hw_q <= prio_hw_d;
      gnt_hw_q  <= gnt_hw_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      fault_q   <= fault_d;
    end
  end

  // Outputs decoded from the registered state only, so they are glitch-free
  // and all drop to zero on the reset edge.
  always_comb begin
    logic ack_cyc;
    logic good;
    ack_cyc    = (state_q == ST_RESP) || (state_q == ST_REJECT);
    good       = (state_q == ST_RESP) && !err_q;
    op_start   = (state_q == ST_ISSUE);
    op         = (state_q == ST_ISSUE) ? op_q : 3'd0;
    sw_ack     = ack_cyc && !gnt_hw_q;
    hw_ack     = ack_cyc && gnt_hw_q;
    sw_err     = ack_cyc && !gnt_hw_q && err_q;
    hw_err     = ack_cyc && gnt_hw_q && err_q;
    data_sw_en = good && ((op_q == OpGenId) || (op_q == OpGenSwOut));
    data_hw_en = good && (op_q == OpGenHwOut);
    data_valid = data_sw_en || data_hw_en;
    busy       = (state_q != ST_IDLE);
    fault      = fault_q;
  end

endmodule

// File: tb/tb_keymgr_op_arbiter.sv
// Bench for keymgr_op_arbiter: directed scenarios followed by randomized
// transactions, all checked against a transaction-level reference model.
module tb_keymgr_op_arbiter;

  localparam int TIMEOUT = 64;
  localparam logic [9:0] ST_RESET = 10'b1101100001;
  localparam logic [9:0] ST_INIT  = 10'b0100000100;
  localparam logic [9:0] ST_OWNER = 10'b1101111110;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_req, hw_req;
  logic [2:0] sw_op, hw_op;
  logic       sw_ack, sw_err, hw_ack, hw_err;
  logic [9:0] ctrl_state;
  logic       op_start;
  logic [2:0] op;
  logic       op_done;
  logic       data_hw_en, data_sw_en, data_valid, busy, fault;

  always #5 clk = ~clk;

  keymgr_op_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .sw_req(sw_req), .sw_op(sw_op), .sw_ack(sw_ack), .sw_err(sw_err),
    .hw_req(hw_req), .hw_op(hw_op), .hw_ack(hw_ack), .hw_err(hw_err),
    .ctrl_state(ctrl_state),
    .op_start(op_start), .op(op), .op_done(op_done),
    .data_hw_en(data_hw_en), .data_sw_en(data_sw_en), .data_valid(data_valid),
    .busy(busy), .fault(fault)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit m_prio_hw;
  bit m_fault;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit permitted(input logic [2:0] o, input logic [9:0] st, input bit flt);
    bit known;
    known = (st == ST_RESET) || (st == ST_INIT) || (st == ST_OWNER);
    if (flt || !known) return 1'b0;
    case (o)
      3'd0:             return (st == ST_RESET) || (st == ST_INIT);
      3'd1, 3'd2, 3'd3: return st == ST_OWNER;
      3'd4:             return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic int all_outputs();
    return int'({op_start, op, sw_ack, sw_err, hw_ack, hw_err,
                 data_hw_en, data_sw_en, data_valid, busy, fault});
  endfunction

  // One transaction: requests are already set up at a negedge with the DUT
  // idle. lat = cycles of op_start before the core answers (> TIMEOUT: never).
  task automatic do_txn(input int lat);
    bit g_hw, perm, exp_err, got_ack;
    logic [2:0] g_op;
    int exp_starts, exp_sw_en, exp_hw_en;
    int n, starts, sw_en_n, hw_en_n, dv_n, stray, op_bad;
    bit ack_sw, ack_hw, ack_err, busy_ack;
    n = 0; starts = 0; sw_en_n = 0; hw_en_n = 0; dv_n = 0; stray = 0; op_bad = 0;
    got_ack = 0; ack_sw = 0; ack_hw = 0; ack_err = 0; busy_ack = 0;

    g_hw       = hw_req && (!sw_req || m_prio_hw);
    g_op       = g_hw ? hw_op : sw_op;
    perm       = permitted(g_op, ctrl_state, m_fault);
    m_prio_hw  = !g_hw;
    exp_starts = !perm ? 0 : ((lat <= TIMEOUT) ? lat : TIMEOUT);
    exp_err    = !perm || (lat > TIMEOUT);
    exp_sw_en  = (!exp_err && (g_op == 3'd1 || g_op == 3'd2)) ? 1 : 0;
    exp_hw_en  = (!exp_err && g_op == 3'd3) ? 1 : 0;

    while (!got_ack && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) ctrl_state = 10'($urandom);
      if (op_start) begin
        starts++;
        if (op !== g_op) op_bad++;
        op_done = (starts == lat);
      end else begin
        op_done = 1'($urandom_range(0, 1));
      end
      if (sw_ack || hw_ack) begin
        got_ack  = 1;
        ack_sw   = sw_ack;
        ack_hw   = hw_ack;
        ack_err  = sw_ack ? sw_err : hw_err;
        busy_ack = busy;
        sw_en_n += int'(data_sw_en);
        hw_en_n += int'(data_hw_en);
        dv_n    += int'(data_valid);
      end else begin
        stray += int'(data_sw_en || data_hw_en || data_valid);
      end
    end

    if (perm && lat > TIMEOUT) m_fault = 1'b1;

    check_val("ack_seen", int'(got_ack), 1);
    check_val("ack_sw", int'(ack_sw), int'(!g_hw));
    check_val("ack_hw", int'(ack_hw), int'(g_hw));
    check_val("ack_err", int'(ack_err), int'(exp_err));
    check_val("op_start_cycles", starts, exp_starts);
    check_val("ack_latency", n, exp_starts + 1);
    check_val("op_code", op_bad, 0);
    check_val("data_sw_en", sw_en_n, exp_sw_en);
    check_val("data_hw_en", hw_en_n, exp_hw_en);
    check_val("data_valid", dv_n, exp_sw_en + exp_hw_en);
    check_val("stray_strobe", stray, 0);
    check_val("busy_at_ack", int'(busy_ack), 1);
    check_val("fault", int'(fault), int'(m_fault));

    if (g_hw) hw_req = 1'b0;
    else      sw_req = 1'b0;
    op_done = 1'b0;
    @(negedge clk);
    check_val("idle_after_ack", int'(busy), 0);
    check_val("no_ack_after", int'(sw_ack || hw_ack), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; sw_req = 1'b0; hw_req = 1'b0; op_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_prio_hw = 1'b0;
    m_fault   = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int acks;
    int r;
    rst = 1'b1; sw_req = 0; hw_req = 0; sw_op = 0; hw_op = 0;
    op_done = 0; ctrl_state = ST_RESET;
    m_prio_hw = 0; m_fault = 0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", all_outputs(), 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_reset_outputs", all_outputs(), 0);

    // permitted advance
    ctrl_state = ST_RESET; sw_req = 1; sw_op = 3'd0;
    do_txn(3);

    // gated generate, then the same op in the owner key state
    ctrl_state = ST_INIT; hw_req = 1; hw_op = 3'd3;
    do_txn(2);
    ctrl_state = ST_OWNER; hw_req = 1; hw_op = 3'd3;
    do_txn(2);

    // an advance in reset state does not unlock the generate ops
    for (int i = 0; i < 4; i++) begin
      ctrl_state = ST_RESET; sw_req = 1; sw_op = 3'(i);
      do_txn(2);
    end

    // contention: both requesting permanently, grants must alternate
    do_reset();
    sw_op = 3'd4; hw_op = 3'd0;
    sw_req = 1; hw_req = 1;
    for (int i = 0; i < 6; i++) begin
      ctrl_state = ST_RESET; sw_req = 1; hw_req = 1;
      check_val("contention_prio", int'(m_prio_hw), i % 2);
      do_txn(2);
    end
    sw_req = 0; hw_req = 0;
    @(negedge clk);

    // timeout, sticky fault, disable rejected until reset
    ctrl_state = ST_OWNER; sw_req = 1; sw_op = 3'd2;
    do_txn(1000);
    ctrl_state = ST_RESET; sw_req = 1; sw_op = 3'd4;
    do_txn(2);
    do_reset();
    check_val("fault_cleared", int'(fault), 0);
    ctrl_state = ST_RESET; sw_req = 1; sw_op = 3'd4;
    do_txn(2);

    // completion on the very last cycle before expiry
    ctrl_state = ST_OWNER; hw_req = 1; hw_op = 3'd1;
    do_txn(TIMEOUT);

    // reset while op_start is high
    ctrl_state = ST_RESET; sw_req = 1; sw_op = 3'd0; op_done = 0;
    repeat (3) @(negedge clk);
    check_val("mid_issue_start", int'(op_start), 1);
    rst = 1'b1; sw_req = 0;
    @(negedge clk);
    rst = 1'b0;
    m_prio_hw = 0; m_fault = 0;
    check_val("mid_reset_outputs", all_outputs(), 0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      acks += int'(sw_ack || hw_ack || op_start);
    end
    check_val("mid_reset_no_ack", acks, 0);
    sw_req = 1; sw_op = 3'd0;
    do_txn(2);

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      if (!sw_req && $urandom_range(0, 1) == 1) begin
        sw_req = 1; sw_op = 3'($urandom_range(0, 7));
      end
      if (!hw_req && $urandom_range(0, 1) == 1) begin
        hw_req = 1; hw_op = 3'($urandom_range(0, 7));
      end
      if (!sw_req && !hw_req) begin
        sw_req = 1; sw_op = 3'($urandom_range(0, 7));
      end
      case ($urandom_range(0, 3))
        0:       ctrl_state = ST_RESET;
        1:       ctrl_state = ST_INIT;
        2:       ctrl_state = ST_OWNER;
        default: ctrl_state = 10'($urandom);
      endcase
      r = int'($urandom_range(0, 9));
      do_txn(r < 7 ? r + 1 : (r == 7 ? TIMEOUT - 1 : TIMEOUT));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
